// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave that decodes a 16-bit instruction and streams bytes into or out of
// an 8-bit register file, with SPI inputs oversampled by the system clock.
`timescale 1ns / 1ps

module spi_reg_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_csb,
  input  logic              spi_sclk,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdo_oe,
  output logic              write,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] wrData,
  input  logic [DATA_W-1:0] rdData,
  output logic              busy,
  output logic              xfer_err
);

  localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned InstrW = 16;

  typedef enum logic [2:0] {StIdle, StInstr, StWdata, StRdata, StDone} state_e;

  logic [Stages-1:0] csb_sync_q, csb_sync_d;
  logic [Stages-1:0] sclk_sync_q, sclk_sync_d;
  logic [Stages-1:0] sdi_sync_q, sdi_sync_d;
  logic              sclk_prev_q, sclk_prev_d;
  logic              csb_s, sclk_s, sdi_s, sclk_rise, sclk_fall;

  state_e              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [InstrW-1:0]   sr_q, sr_d;
  logic [1:0]          bytes_rem_q, bytes_rem_d;
  logic                stream_q, stream_d;
  logic                dec_pend_q, dec_pend_d;
  logic                load_pend_q, load_pend_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                write_q, write_d;
  logic                sdo_q, sdo_d;
  logic                sdo_oe_q, sdo_oe_d;
  logic                busy_q, busy_d;
  logic                xfer_err_q, xfer_err_d;
  logic [InstrW-1:0]   instr_w;
  logic                more_bytes;

  assign csb_s     = csb_sync_q[Stages-1];
  assign sclk_s    = sclk_sync_q[Stages-1];
  assign sdi_s     = sdi_sync_q[Stages-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  assign instr_w    = {sr_q[InstrW-2:0], sdi_s};
  assign more_bytes = stream_q || (bytes_rem_q != 2'd0);

  always_comb begin
    csb_sync_d  = {csb_sync_q[Stages-2:0], spi_csb};
    sclk_sync_d = {sclk_sync_q[Stages-2:0], spi_sclk};
    sdi_sync_d  = {sdi_sync_q[Stages-2:0], spi_sdi};
    sclk_prev_d = sclk_s;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    bytes_rem_d = bytes_rem_q;
    stream_d    = stream_q;
    dec_pend_d  = 1'b0;
    load_pend_d = 1'b0;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    write_d     = 1'b0;
    sdo_d       = sdo_q;
    sdo_oe_d    = sdo_oe_q;
    xfer_err_d  = 1'b0;

    // Address steps down the cycle after each write strobe, even after the last byte.
    if (dec_pend_q) addr_d = addr_q - ADDR_W'(1);

    unique case (state_q)
      StIdle: begin
        sdo_oe_d = 1'b0;
        if (!csb_s) begin
          state_d   = StInstr;
          bit_cnt_d = 4'd0;
        end
      end
      StInstr: begin
        if (sclk_rise) begin
          sr_d      = instr_w;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(InstrW - 1)) begin
            bit_cnt_d   = 4'd0;
            addr_d      = instr_w[ADDR_W-1:0];
            bytes_rem_d = instr_w[14:13];
            stream_d    = &instr_w[14:13];
            if (instr_w[15]) begin
              state_d     = StRdata;
              load_pend_d = 1'b1;
            end else begin
              state_d = StWdata;
            end
          end
        end
      end
      StWdata: begin
        if (sclk_rise) begin
          sr_d[DATA_W-1:0] = {sr_q[DATA_W-2:0], sdi_s};
          bit_cnt_d        = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(DATA_W - 1)) begin
            bit_cnt_d  = 4'd0;
            write_d    = 1'b1;
            wr_data_d  = {sr_q[DATA_W-2:0], sdi_s};
            dec_pend_d = 1'b1;
            if (more_bytes) begin
              if (!stream_q) bytes_rem_d = bytes_rem_q - 2'd1;
            end else begin
              state_d = StDone;
            end
          end
        end
      end
      StRdata: begin
        if (load_pend_q) sr_d[DATA_W-1:0] = rdData;
        if (sclk_fall) begin
          sdo_d            = sr_q[DATA_W-1];
          sdo_oe_d         = 1'b1;
          sr_d[DATA_W-1:0] = {sr_q[DATA_W-2:0], 1'b0};
        end
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(DATA_W - 1)) begin
            bit_cnt_d   = 4'd0;
            addr_d      = addr_q - ADDR_W'(1);
            load_pend_d = 1'b1;
            if (more_bytes) begin
              if (!stream_q) bytes_rem_d = bytes_rem_q - 2'd1;
            end else begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        sdo_d     = 1'b0;
        sdo_oe_d  = 1'b0;
        bit_cnt_d = 4'd0;
      end
      default: state_d = StIdle;
    endcase

    // CSB high ends the transfer; a partial byte or instruction is dropped and flagged.
    if (state_q != StIdle && csb_s) begin
      state_d     = StIdle;
      sdo_d       = 1'b0;
      sdo_oe_d    = 1'b0;
      write_d     = 1'b0;
      dec_pend_d  = 1'b0;
      load_pend_d = 1'b0;
      bit_cnt_d   = 4'd0;
      xfer_err_d  = (state_q == StInstr) || (bit_cnt_q != 4'd0);
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csb_sync_q  <= {Stages{1'b1}};
      sclk_sync_q <= '0;
      sdi_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= StIdle;
      bit_cnt_q   <= 4'd0;
      sr_q        <= '0;
      bytes_rem_q <= 2'd0;
      stream_q    <= 1'b0;
      dec_pend_q  <= 1'b0;
      load_pend_q <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      write_q     <= 1'b0;
      sdo_q       <= 1'b0;
      sdo_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      xfer_err_q  <= 1'b0;
    end else begin
      csb_sync_q  <= csb_sync_d;
      sclk_sync_q <= sclk_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      bytes_rem_q <= bytes_rem_d;
      stream_q    <= stream_d;
      dec_pend_q  <= dec_pend_d;
      load_pend_q <= load_pend_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      write_q     <= write_d;
      sdo_q       <= sdo_d;
      sdo_oe_q    <= sdo_oe_d;
      busy_q      <= busy_d;
      xfer_err_q  <= xfer_err_d;
    end
  end

  assign spi_sdo    = sdo_q;
  assign spi_sdo_oe = sdo_oe_q;
  assign write      = write_q;
  assign Addr       = addr_q;
  assign wrData     = wr_data_q;
  assign busy       = busy_q;
  assign xfer_err   = xfer_err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: an SPI master task set, a register-file model fed by
// the write strobe, and immediate-assertion checks against hand-computed values.
`timescale 1ns / 1ps

module tb_spi_reg_ctrl;

  localparam int HALF = 50;

  logic        clk;
  logic        reset;
  logic        spi_csb, spi_sclk, spi_sdi;
  logic        spi_sdo, spi_sdo_oe;
  logic        write;
  logic [12:0] Addr;
  logic [7:0]  wrData;
  logic [7:0]  rdData;
  logic        busy, xfer_err;

  logic [7:0]  mem [0:8191];
  logic [12:0] wr_addr [0:63];
  logic [7:0]  wr_data [0:63];
  int          wr_cnt = 0;
  int          err_cnt = 0;
  int          oe_bad = 0;
  logic        instr_phase;

  int          tests = 0;
  int          fails = 0;
  int          base_w, base_e;
  logic [7:0]  rx0, rx1, rxd;
  logic        rb;

  spi_reg_ctrl #(
    .SYNC_STAGES(2),
    .ADDR_W     (13),
    .DATA_W     (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_csb   (spi_csb),
    .spi_sclk  (spi_sclk),
    .spi_sdi   (spi_sdi),
    .spi_sdo   (spi_sdo),
    .spi_sdo_oe(spi_sdo_oe),
    .write     (write),
    .Addr      (Addr),
    .wrData    (wrData),
    .rdData    (rdData),
    .busy      (busy),
    .xfer_err  (xfer_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rdData = mem[Addr];

  always @(negedge clk) begin
    if (write) begin
      wr_addr[wr_cnt % 64] <= Addr;
      wr_data[wr_cnt % 64] <= wrData;
      wr_cnt               <= wr_cnt + 1;
      mem[Addr]            <= wrData;
    end
    if (xfer_err) err_cnt <= err_cnt + 1;
    if (spi_sdo_oe && instr_phase) oe_bad <= oe_bad + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    spi_sdi = b;
    #HALF;
    spi_sclk = 1'b1;
    r = spi_sdo;
    #HALF;
    spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic send_instr(input logic [15:0] ins);
    logic [7:0] d;
    instr_phase = 1'b1;
    spi_byte(ins[15:8], d);
    spi_byte(ins[7:0], d);
    instr_phase = 1'b0;
  endtask

  task automatic cs_low();
    spi_csb = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    spi_csb = 1'b1;
    #(HALF * 2);
  endtask

  initial begin
    reset       = 1'b1;
    spi_csb     = 1'b1;
    spi_sclk    = 1'b0;
    spi_sdi     = 1'b0;
    instr_phase = 1'b0;
    #20;
    check("rst_write",    32'(write), 32'h0);
    check("rst_addr",     32'(Addr), 32'h0);
    check("rst_wrdata",   32'(wrData), 32'h0);
    check("rst_sdo",      32'(spi_sdo), 32'h0);
    check("rst_sdo_oe",   32'(spi_sdo_oe), 32'h0);
    check("rst_busy",     32'(busy), 32'h0);
    check("rst_xfer_err", 32'(xfer_err), 32'h0);
    #30;
    reset = 1'b0;
    #50;

    // Single write
    base_w = wr_cnt; base_e = err_cnt;
    cs_low();
    send_instr(16'h0014);
    check("single_busy_hi", 32'(busy), 32'h1);
    spi_byte(8'hA5, rxd);
    cs_high();
    check("single_nwr",   32'(wr_cnt - base_w), 32'd1);
    check("single_addr",  32'(wr_addr[base_w]), 32'h014);
    check("single_data",  32'(wr_data[base_w]), 32'hA5);
    check("single_err",   32'(err_cnt - base_e), 32'd0);
    check("single_busy_lo", 32'(busy), 32'h0);

    // Streaming write with address wrap
    base_w = wr_cnt; base_e = err_cnt;
    cs_low();
    send_instr(16'h6002);
    spi_byte(8'h11, rxd);
    spi_byte(8'h22, rxd);
    spi_byte(8'h33, rxd);
    spi_byte(8'h44, rxd);
    cs_high();
    check("stream_nwr", 32'(wr_cnt - base_w), 32'd4);
    check("stream_a0", 32'(wr_addr[base_w]),     32'h0002);
    check("stream_d0", 32'(wr_data[base_w]),     32'h11);
    check("stream_a1", 32'(wr_addr[base_w + 1]), 32'h0001);
    check("stream_d1", 32'(wr_data[base_w + 1]), 32'h22);
    check("stream_a2", 32'(wr_addr[base_w + 2]), 32'h0000);
    check("stream_d2", 32'(wr_data[base_w + 2]), 32'h33);
    check("stream_a3", 32'(wr_addr[base_w + 3]), 32'h1FFF);
    check("stream_d3", 32'(wr_data[base_w + 3]), 32'h44);
    check("stream_err", 32'(err_cnt - base_e), 32'd0);

    // Preload 0x0FF=0x01, 0x0FE=0x5A (0x0FF treated as ordinary), then 0x123=0xFF
    base_w = wr_cnt;
    cs_low();
    send_instr(16'h20FF);
    spi_byte(8'h01, rxd);
    spi_byte(8'h5A, rxd);
    cs_high();
    cs_low();
    send_instr(16'h0123);
    spi_byte(8'hFF, rxd);
    cs_high();
    check("preload_nwr", 32'(wr_cnt - base_w), 32'd3);
    check("preload_a0ff", 32'(wr_addr[base_w]), 32'h0FF);

    // Burst read
    base_w = wr_cnt; base_e = err_cnt;
    cs_low();
    send_instr(16'hA0FF);
    spi_byte(8'h00, rx0);
    check("read_oe_mid", 32'(spi_sdo_oe), 32'h1);
    spi_byte(8'h00, rx1);
    cs_high();
    check("read_byte0", 32'(rx0), 32'h01);
    check("read_byte1", 32'(rx1), 32'h5A);
    check("read_nwr", 32'(wr_cnt - base_w), 32'd0);
    check("read_oe_instr", 32'(oe_bad), 32'd0);
    check("read_oe_end", 32'(spi_sdo_oe), 32'h0);
    check("read_err", 32'(err_cnt - base_e), 32'd0);

    // Abort mid-byte
    base_w = wr_cnt; base_e = err_cnt;
    cs_low();
    send_instr(16'h0030);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, rb);
    cs_high();
    check("abort_nwr", 32'(wr_cnt - base_w), 32'd0);
    check("abort_err", 32'(err_cnt - base_e), 32'd1);
    check("abort_busy", 32'(busy), 32'h0);
    base_w = wr_cnt;
    cs_low();
    send_instr(16'h0031);
    spi_byte(8'h7E, rxd);
    cs_high();
    check("after_abort_nwr",  32'(wr_cnt - base_w), 32'd1);
    check("after_abort_addr", 32'(wr_addr[base_w]), 32'h031);
    check("after_abort_data", 32'(wr_data[base_w]), 32'h7E);
    check("after_abort_err",  32'(err_cnt - base_e), 32'd1);

    // Async reset during the 3rd data bit of a read of 0x123 (0xFF)
    base_w = wr_cnt; base_e = err_cnt;
    cs_low();
    send_instr(16'h8123);
    spi_bit(1'b0, rb);
    spi_bit(1'b0, rb);
    #30;
    check("pre_rst_sdo",  32'(spi_sdo), 32'h1);
    check("pre_rst_oe",   32'(spi_sdo_oe), 32'h1);
    check("pre_rst_addr", 32'(Addr), 32'h123);
    reset = 1'b1;
    #1;
    check("async_rst_sdo",  32'(spi_sdo), 32'h0);
    check("async_rst_oe",   32'(spi_sdo_oe), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_addr", 32'(Addr), 32'h0);
    #9;
    spi_csb  = 1'b1;
    spi_sclk = 1'b0;
    #40;
    reset = 1'b0;
    #50;
    check("async_rst_nwr", 32'(wr_cnt - base_w), 32'd0);
    base_w = wr_cnt; base_e = err_cnt;
    cs_low();
    send_instr(16'h0055);
    spi_byte(8'h3C, rxd);
    cs_high();
    check("post_rst_nwr",  32'(wr_cnt - base_w), 32'd1);
    check("post_rst_addr", 32'(wr_addr[base_w]), 32'h055);
    check("post_rst_data", 32'(wr_data[base_w]), 32'h3C);
    check("post_rst_err",  32'(err_cnt - base_e), 32'd0);

    // Byte-count limit: 2-byte write with 3 bytes clocked
    base_w = wr_cnt; base_e = err_cnt;
    cs_low();
    send_instr(16'h2010);
    spi_byte(8'hAA, rxd);
    spi_byte(8'hBB, rxd);
    spi_byte(8'hCC, rxd);
    cs_high();
    check("limit_nwr", 32'(wr_cnt - base_w), 32'd2);
    check("limit_a0", 32'(wr_addr[base_w]),     32'h010);
    check("limit_d0", 32'(wr_data[base_w]),     32'hAA);
    check("limit_a1", 32'(wr_addr[base_w + 1]), 32'h00F);
    check("limit_d1", 32'(wr_data[base_w + 1]), 32'hBB);
    check("limit_err", 32'(err_cnt - base_e), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- SPI slave controller that sequences the 8-bit × 8192-entry AD9643 register file.
- Decodes the 16-bit instruction phase (R/W, byte count W1:W0, 13-bit address), then streams data bytes into or out of the register file through its write/Addr/wrData/rdData port.
- Sits between the external SPI pins (CSB, SCLK, SDIO split into in/out/oe) and the register file. Oversamples SPI with the system clock.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on spi_csb, spi_sclk and spi_sdi (minimum 2).
- ADDR_W, 13, register-file address width.
- DATA_W, 8, register-file data width. The protocol assumes 8.

Ports:
- clk  in  1  system clock. Must be at least 8× the SCLK frequency.
- reset  in  1  asynchronous, active-high reset.
- spi_csb  in  1  SPI chip select, active low.
- spi_sclk  in  1  SPI clock.
- spi_sdi  in  1  SPI serial data in.
- spi_sdo  out  1  SPI serial data out.
- spi_sdo_oe  out  1  SDO output enable, high during the read data phase.
- write  out  1  register-file write strobe, one clk wide.
- Addr  out  ADDR_W  register-file address.
- wrData  out  DATA_W  register-file write data.
- rdData  in  DATA_W  register-file combinational read data at Addr.
- busy  out  1  high while CSB is synchronised low.
- xfer_err  out  1  one-clk pulse when CSB rises mid-byte or mid-instruction.

Behaviour:
- Reset:
  - All outputs 0: write, Addr, wrData, spi_sdo, spi_sdo_oe, busy, xfer_err.
  - State goes to IDLE; bit counter, shift registers and byte counter are cleared.
  - Reset asserted mid-transfer aborts the transfer immediately. No write is issued.
- Synchronisation:
  - spi_csb, spi_sclk and spi_sdi each pass through SYNC_STAGES flops.
  - sclk_rise and sclk_fall are single-clk strobes from the synchronised SCLK.
  - All timing below is relative to these strobes.
- Protocol:
  - SPI mode 0, MSB first.
  - Data is sampled on sclk_rise; SDO is updated on sclk_fall.
- Instruction format (16 bits): [15] R/W (1 = read), [14:13] W1:W0, [12:0] start address.
- Byte count from W1:W0: 00 → 1 byte, 01 → 2, 10 → 3, 11 → streaming until CSB rises.
- States:
  - IDLE: on synchronised CSB fall → INSTR; busy = 1; bit counter cleared.
  - INSTR: shift 16 bits on sclk_rise. On the 16th rise, latch Addr ← bits[12:0] and the byte count, then go to WDATA or RDATA.
  - WDATA: shift 8 bits on sclk_rise. The clk after the 8th rise:
    - write = 1 and wrData = assembled byte at the current Addr.
    - Next cycle, Addr decrements by 1.
    - If bytes remain → WDATA; otherwise → DONE.
  - RDATA:
    - On entry, load the shift register from rdData at Addr.
    - On each sclk_fall: spi_sdo = shift MSB, spi_sdo_oe = 1, then shift left.
    - After the 8th bit has been driven and the following sclk_rise occurs, decrement Addr.
    - The clk after the decrement, reload from rdData. If bytes remain → RDATA; otherwise → DONE.
  - DONE: ignore SCLK; spi_sdo_oe = 0; wait for CSB rise.
- CSB rise in any state:
  - Return to IDLE; busy = 0 and spi_sdo_oe = 0 in the next clk.
  - If bit counter ≠ 0, or state = INSTR, pulse xfer_err and discard the partial byte (no write).
  - A CSB rise exactly on a byte boundary in streaming mode is a normal end (no xfer_err).
- Address arithmetic:
  - Modulo 2^ADDR_W decrement, so 0x0000 wraps to 0x1FFF.
  - Addr holds its last value in IDLE.
- write never asserts in INSTR, RDATA, DONE or IDLE.
- At most one write per 8 SCLK periods.
- The register file's self-clearing transfer register (0x0FF bit 0) is not special-cased here. Writing 0x01 to 0x0FF is an ordinary write.

Test Plan:
- Single write:
  - Stimulus: CSB low; instruction 0x0014 (write, 1 byte, addr 0x014); data 0xA5; CSB high.
  - Required: exactly one write pulse with Addr = 0x014, wrData = 0xA5; xfer_err = 0; busy falls after CSB rises.
- Streaming write:
  - Stimulus: instruction 0x6002 (write, W = 11, addr 0x002); bytes 0x11, 0x22, 0x33, 0x44; CSB high.
  - Required: writes at 0x002, 0x001, 0x000, 0x1FFF with data 0x11, 0x22, 0x33, 0x44 (wrap verified).
- Burst read:
  - Stimulus: regfile model holds 0x0FF = 0x01, 0x0FE = 0x5A; instruction 0xA0FF (read, 2 bytes, addr 0x0FF).
  - Required: SDO shifts 0x01 then 0x5A MSB first; spi_sdo_oe high only in the data phase; no write pulses.
- Abort mid-byte:
  - Stimulus: write instruction 0x0030, then 5 data bits, then CSB high.
  - Required: no write; one xfer_err pulse; state returns to IDLE; the next full transaction succeeds.
- Async reset mid-read:
  - Stimulus: assert reset during the 3rd data bit of a read.
  - Required: spi_sdo, spi_sdo_oe, busy, Addr = 0 immediately (no clk edge needed); the following transaction decodes correctly.
- Byte-count limit:
  - Stimulus: instruction 0x2010 (write, 2 bytes) with 3 data bytes clocked.
  - Required: only 2 writes (0x010, 0x00F); the 3rd byte is ignored in DONE; no xfer_err.
